l2_mm_line_engine: RTL and testbench
====================================

L2_MM_LINE_ENGINE -- requirements
Module: l2_mm_line_engine

Interface
REQ-001 Parameters SHALL be: N=32 (word width); BLOCK_WORDS=16 (words per line); ADDR_W=15 (main-memory word address width).
REQ-002 Ports SHALL be, as name  direction  width  meaning:
  clk  in  1  single clock; all state changes on its rising edge.
  reset  in  1  synchronous, active-low (0 = reset).
  start  in  1  command strobe; sampled only in IDLE.
  op  in  2  01 FILL, 10 WB, 11 WB_FILL (writeback then fill), 00 no-op.
  wb_block  in  11  block number to write back.
  fill_block  in  11  block number to fill.
  crit_offset  in  4  critical word offset; used only with CRIT_WORD_FIRST_EN.
  wb_line  in  N*16  writeback line; word k in bits [32k+31:32k].
  fill_line  out  N*16  assembled fill line, same packing.
  fill_word_valid  out  1  one-cycle pulse per captured fill word.
  fill_word_idx  out  4  offset of the word flagged by fill_word_valid.
  crit_valid  out  1  pulse when the critical word is captured (macro only).
  done  out  1  one-cycle pulse at command completion.
  eng_busy  out  1  high in every state except IDLE.
  L2_read_request  out  1  main-memory read request.
  L2_write_request  out  1  main-memory write request.
  L2_word_address  out  15  {block, offset}.
  L2_wdata  out  N  write data word.
  L2_rdata  in  N  read data word from main memory.
  MM_busy  in  1  main memory in its access cycle.

Function
REQ-003 States SHALL be IDLE, WB, RD, RD_LAST, DONE.
REQ-004 In IDLE, start=1 with op!=00 SHALL latch op, both block numbers, crit_offset and wb_line, then move to WB (op 10/11) or RD (op 01); start with op=00 or outside IDLE SHALL be ignored.
REQ-005 WB and RD SHALL hold their respective request high continuously; L2_read_request and L2_write_request SHALL never both be high.
REQ-006 A word SHALL complete on a cycle where the request is high and MM_busy=1; offset advances on the next edge, giving 2 cycles per word.
REQ-007 In WB, L2_wdata SHALL be the latched wb_line word for the current offset; after word 15 completes, go to RD for op 11 and to DONE for op 10.
REQ-008 In RD, L2_rdata SHALL be captured into the line buffer in the cycle after each completion, overlapping the next word's issue.
REQ-009 After the 16th read completes, go to RD_LAST with requests low, capture the final word, then go to DONE.
REQ-010 DONE SHALL pulse done for one cycle and then return to IDLE; for fills, fill_line SHALL be complete while done=1 and held until the next fill starts.
REQ-011 Each capture SHALL pulse fill_word_valid with fill_word_idx equal to that word's offset.
REQ-012 Latency, with the start cycle as cycle 0: WB done at cycle 33; FILL done at cycle 34; WB_FILL done at cycle 66.
REQ-013 Offset arithmetic SHALL be 4-bit modulo 16; word 15 wraps to 0.

Reset
REQ-014 reset=0 at a clock edge SHALL force IDLE and drive all outputs to 0, including fill_line, from the following cycle.
REQ-015 Reset mid-command SHALL abort the command without issuing done; requests drop on the same edge.

Configuration
REQ-016 With CRIT_WORD_FIRST_EN defined, fills SHALL start at crit_offset and wrap modulo 16, and crit_valid SHALL pulse with the first capture.
REQ-017 Without CRIT_WORD_FIRST_EN, fills SHALL start at offset 0, crit_offset SHALL be ignored, and crit_valid SHALL be tied to 0; ports are present in both builds.

Structure
REQ-018 Package cache_pkg SHALL hold the op encoding enum, N, BLOCK_WORDS, ADDR_W and the state enum.
REQ-019 The line buffer (16xN, single-word write, full-line read) SHALL be sub-module l2_line_buffer.

Verification
REQ-020 FILL of block 0x005 with a preloaded memory -> addresses 0x0050..0x005F, fill_line equals memory contents, done at cycle 34.
REQ-021 WB of block 0x7FF with wb_line word k = 0xA000_0000+k -> ram[0x7FF0+k] written, done at cycle 33, L2_read_request never high.
REQ-022 WB_FILL with wb_block 0x001 and fill_block 0x002 -> 16 writes then 16 reads with no idle gap, single done at cycle 66.
REQ-023 Macro defined, crit_offset=14 -> fill_word_idx sequence 14,15,0..13 and crit_valid with idx 14; macro undefined -> sequence 0..15.
REQ-024 reset=0 during the 5th read word, then a new FILL -> no done for the aborted command, new fill correct, start pulses while eng_busy=1 ignored.

Source files
------------

// File: rtl/l2_mm_line_engine_pkg.sv
// Shared types and sizing for the L2 <-> main-memory line engine.
package cache_pkg;

  localparam int unsigned N           = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned OFF_W       = 4;
  localparam int unsigned BLK_W       = ADDR_W - OFF_W;
  localparam int unsigned LINE_W      = N * BLOCK_WORDS;

  typedef enum logic [1:0] {
    OpNop    = 2'b00,
    OpFill   = 2'b01,
    OpWb     = 2'b10,
    OpWbFill = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWb,
    StRd,
    StRdLast,
    StDone
  } state_e;

endpackage

// File: rtl/l2_mm_line_engine_if.sv
// Command and main-memory bus bundle of the line engine.
interface l2_mm_line_engine_if;
  import cache_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [BLK_W-1:0]  wb_block;
  logic [BLK_W-1:0]  fill_block;
  logic [OFF_W-1:0]  crit_offset;
  logic [LINE_W-1:0] wb_line;
  logic [LINE_W-1:0] fill_line;
  logic              fill_word_valid;
  logic [OFF_W-1:0]  fill_word_idx;
  logic              crit_valid;
  logic              done;
  logic              eng_busy;
  logic              L2_read_request;
  logic              L2_write_request;
  logic [ADDR_W-1:0] L2_word_address;
  logic [N-1:0]      L2_wdata;
  logic [N-1:0]      L2_rdata;
  logic              MM_busy;

  // Requester / memory-environment side.
  modport master (
    output start, op, wb_block, fill_block, crit_offset, wb_line, L2_rdata, MM_busy,
    input  fill_line, fill_word_valid, fill_word_idx, crit_valid, done, eng_busy,
    input  L2_read_request, L2_write_request, L2_word_address, L2_wdata
  );

  // Engine side.
  modport slave (
    input  start, op, wb_block, fill_block, crit_offset, wb_line, L2_rdata, MM_busy,
    output fill_line, fill_word_valid, fill_word_idx, crit_valid, done, eng_busy,
    output L2_read_request, L2_write_request, L2_word_address, L2_wdata
  );

endinterface

// File: rtl/l2_line_buffer.sv
// 16-word line buffer: one word written per cycle, whole line always readable.
module l2_line_buffer
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [OFF_W-1:0]  i_idx,
  input  logic [N-1:0]      i_wdata,
  output logic [LINE_W-1:0] o_line
);

  logic [N-1:0] r_mem [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < BLOCK_WORDS; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_pack
    assign o_line[g*N +: N] = r_mem[g];
  end

endmodule

// File: rtl/l2_mm_line_engine.sv
// Line writeback/fill engine between L2 and a 2-cycle-per-word main memory.
// Define CRIT_WORD_FIRST_EN to start fills at crit_offset and pulse crit_valid.
module l2_mm_line_engine
  import cache_pkg::*;
(
  input logic                clk,
  input logic                reset,
  l2_mm_line_engine_if.slave io_bus
);

`ifdef CRIT_WORD_FIRST_EN
  localparam bit CritEn = 1'b1;
`else
  localparam bit CritEn = 1'b0;
`endif

  state_e            r_state;
  op_e               r_op;
  logic [BLK_W-1:0]  r_wb_block;
  logic [BLK_W-1:0]  r_fill_block;
  logic [OFF_W-1:0]  r_crit_offset;
  logic [LINE_W-1:0] r_wb_line;
  logic [OFF_W-1:0]  r_offset;
  logic [OFF_W-1:0]  r_cnt;
  logic              r_done;
  logic              r_fill_word_valid;
  logic [OFF_W-1:0]  r_fill_word_idx;
  logic              r_crit_valid;

  op_e               w_op;
  logic              w_last;
  logic [OFF_W-1:0]  w_start_new;
  logic [OFF_W-1:0]  w_start_lat;

  assign w_op   = op_e'(io_bus.op);
  assign w_last = (r_cnt == OFF_W'(BLOCK_WORDS - 1));
  // Fill start offset: from the live input for a plain FILL, latched for WB_FILL.
  assign w_start_new = CritEn ? io_bus.crit_offset : '0;
  assign w_start_lat = CritEn ? r_crit_offset : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state           <= StIdle;
      r_op              <= OpNop;
      r_wb_block        <= '0;
      r_fill_block      <= '0;
      r_crit_offset     <= '0;
      r_wb_line         <= '0;
      r_offset          <= '0;
      r_cnt             <= '0;
      r_done            <= 1'b0;
      r_fill_word_valid <= 1'b0;
      r_fill_word_idx   <= '0;
      r_crit_valid      <= 1'b0;
    end else begin
      r_done            <= 1'b0;
      r_fill_word_valid <= 1'b0;
      r_crit_valid      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start && (w_op != OpNop)) begin
            r_op          <= w_op;
            r_wb_block    <= io_bus.wb_block;
            r_fill_block  <= io_bus.fill_block;
            r_crit_offset <= io_bus.crit_offset;
            r_wb_line     <= io_bus.wb_line;
            r_cnt         <= '0;
            if (w_op == OpFill) begin
              r_state  <= StRd;
              r_offset <= w_start_new;
            end else begin
              r_state  <= StWb;
              r_offset <= '0;
            end
          end
        end
        StWb: begin
          if (io_bus.MM_busy) begin
            r_offset <= r_offset + 1'b1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              if (r_op == OpWbFill) begin
                r_state  <= StRd;
                r_offset <= w_start_lat;
                r_cnt    <= '0;
              end else begin
                r_state <= StDone;
                r_done  <= 1'b1;
              end
            end
          end
        end
        StRd: begin
          if (io_bus.MM_busy) begin
            // Memory returns the word next cycle; flag that cycle as the capture.
            r_fill_word_valid <= 1'b1;
            r_fill_word_idx   <= r_offset;
            r_crit_valid      <= CritEn && (r_cnt == '0);
            r_offset          <= r_offset + 1'b1;
            r_cnt             <= r_cnt + 1'b1;
            if (w_last) r_state <= StRdLast;
          end
        end
        StRdLast: begin
          r_state <= StDone;
          r_done  <= 1'b1;
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  l2_line_buffer u_line_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_we    (r_fill_word_valid),
    .i_idx   (r_fill_word_idx),
    .i_wdata (io_bus.L2_rdata),
    .o_line  (io_bus.fill_line)
  );

  always_comb begin
    io_bus.L2_word_address = '0;
    io_bus.L2_wdata        = '0;
    if (r_state == StWb) begin
      io_bus.L2_word_address = {r_wb_block, r_offset};
      io_bus.L2_wdata        = r_wb_line[r_offset*N +: N];
    end else if (r_state == StRd) begin
      io_bus.L2_word_address = {r_fill_block, r_offset};
    end
  end

  assign io_bus.L2_read_request  = (r_state == StRd);
  assign io_bus.L2_write_request = (r_state == StWb);
  assign io_bus.eng_busy         = (r_state != StIdle);
  assign io_bus.done             = r_done;
  assign io_bus.fill_word_valid  = r_fill_word_valid;
  assign io_bus.fill_word_idx    = r_fill_word_idx;
  assign io_bus.crit_valid       = r_crit_valid;

endmodule

// File: tb/tb_l2_mm_line_engine.sv
// Directed bench for l2_mm_line_engine with a 2-cycle-per-word memory model.
module tb_l2_mm_line_engine;
  import cache_pkg::*;

`ifdef CRIT_WORD_FIRST_EN
  localparam bit TbCrit = 1'b1;
`else
  localparam bit TbCrit = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  l2_mm_line_engine_if bus ();

  l2_mm_line_engine dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  // Memory: busy on the cycle after a request, word access on the busy cycle.
  logic [N-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (!reset) begin
      bus.MM_busy  <= 1'b0;
      bus.L2_rdata <= '0;
      for (int i = 0; i < 256; i++) ram[i] <= {16'hC0DE, 16'(i)};
    end else begin
      bus.MM_busy <= (bus.L2_read_request | bus.L2_write_request) & ~bus.MM_busy;
      if (bus.MM_busy && bus.L2_write_request) ram[bus.L2_word_address] <= bus.L2_wdata;
      if (bus.MM_busy && bus.L2_read_request) bus.L2_rdata <= ram[bus.L2_word_address];
    end
  end

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0, done_cyc = 0, n_idx = 0, n_rd = 0, n_wr = 0, crit_cnt = 0;
  int both_hi = 0, rdreq_cyc = 0, rd_rise = 0, last_wr = 0;
  logic prev_rd = 1'b0;
  logic [3:0] crit_idx = '0;
  logic [LINE_W-1:0] done_line = '0;
  logic [3:0]  idx_log [256];
  logic [14:0] rd_log  [256];
  logic [14:0] wr_log  [256];

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_line = bus.fill_line;
    end
    if (bus.fill_word_valid === 1'b1) begin
      idx_log[n_idx % 256] = bus.fill_word_idx;
      n_idx++;
    end
    if (bus.crit_valid === 1'b1) begin
      crit_cnt++;
      crit_idx = bus.fill_word_idx;
    end
    if (bus.L2_read_request === 1'b1 && bus.L2_write_request === 1'b1) both_hi++;
    if (bus.L2_read_request === 1'b1) rdreq_cyc++;
    if (bus.L2_read_request === 1'b1 && !prev_rd) rd_rise = cyc;
    prev_rd = (bus.L2_read_request === 1'b1);
    if (bus.MM_busy === 1'b1 && bus.L2_read_request === 1'b1) begin
      rd_log[n_rd % 256] = bus.L2_word_address;
      n_rd++;
    end
    if (bus.MM_busy === 1'b1 && bus.L2_write_request === 1'b1) begin
      wr_log[n_wr % 256] = bus.L2_word_address;
      n_wr++;
      last_wr = cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] line_of(input logic [N-1:0] b);
    logic [LINE_W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*N +: N] = b + N'(k);
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] exp_addrs(input logic [10:0] blk, input int st);
    logic [LINE_W-1:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*15 +: 15] = {blk, 4'(st + k)};
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] exp_idx(input int st);
    logic [LINE_W-1:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*4 +: 4] = 4'(st + k);
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] got_rd(input int from);
    logic [LINE_W-1:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*15 +: 15] = rd_log[(from + k) % 256];
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] got_wr(input int from);
    logic [LINE_W-1:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*15 +: 15] = wr_log[(from + k) % 256];
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] got_idx(input int from);
    logic [LINE_W-1:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*4 +: 4] = idx_log[(from + k) % 256];
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [10:0] wb, input logic [10:0] fb,
                       input logic [3:0] crit, input logic [LINE_W-1:0] line);
    @(posedge clk); #1;
    base            = cyc;
    bus.start       = 1'b1;
    bus.op          = op;
    bus.wb_block    = wb;
    bus.fill_block  = fb;
    bus.crit_offset = crit;
    bus.wb_line     = line;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 512'(n < 200), 512'(1));
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic wait_rel(input int rel);
    while (cyc - base < rel) begin
      @(posedge clk); #1;
    end
  endtask

  int d0, i0, r0, w0, c0, q0, b0;
  logic [LINE_W-1:0] obs;

  initial begin
    bus.start       = 1'b0;
    bus.op          = 2'b00;
    bus.wb_block    = '0;
    bus.fill_block  = '0;
    bus.crit_offset = '0;
    bus.wb_line     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 512'(bus.eng_busy), 512'(0));
    chk("rst_req", 512'({bus.L2_read_request, bus.L2_write_request}), 512'(0));
    chk("rst_done", 512'({bus.done, bus.fill_word_valid, bus.crit_valid}), 512'(0));
    chk("rst_addr", 512'({bus.L2_word_address, bus.L2_wdata}), 512'(0));
    chk("rst_line", bus.fill_line, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // op=00 start is ignored
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("nop_busy", 512'(bus.eng_busy), 512'(0));

    // FILL block 0x005
    d0 = done_cnt; i0 = n_idx; r0 = n_rd; w0 = n_wr;
    issue(2'b01, 11'h000, 11'h005, 4'h0, '0);
    wait_done("fill_timeout");
    chk("fill_done_cyc", 512'(done_cyc - base), 512'(34));
    chk("fill_done_cnt", 512'(done_cnt - d0), 512'(1));
    chk("fill_rd_cnt", 512'(n_rd - r0), 512'(16));
    chk("fill_wr_cnt", 512'(n_wr - w0), 512'(0));
    chk("fill_addr", got_rd(r0), exp_addrs(11'h005, 0));
    chk("fill_line", done_line, line_of(32'hC0DE_0050));
    chk("fill_idx", got_idx(i0), exp_idx(0));

    // WB block 0x7FF
    d0 = done_cnt; w0 = n_wr; q0 = rdreq_cyc;
    issue(2'b10, 11'h7FF, 11'h000, 4'h0, line_of(32'hA000_0000));
    wait_done("wb_timeout");
    chk("wb_done_cyc", 512'(done_cyc - base), 512'(33));
    chk("wb_done_cnt", 512'(done_cnt - d0), 512'(1));
    chk("wb_wr_cnt", 512'(n_wr - w0), 512'(16));
    chk("wb_rdreq", 512'(rdreq_cyc - q0), 512'(0));
    for (int k = 0; k < 16; k++) obs[k*N +: N] = ram[15'h7FF0 + 15'(k)];
    chk("wb_ram", obs, line_of(32'hA000_0000));
    chk("wb_line_held", bus.fill_line, line_of(32'hC0DE_0050));

    // WB_FILL wb 0x001, fill 0x002, crit_offset 14
    d0 = done_cnt; i0 = n_idx; r0 = n_rd; w0 = n_wr; c0 = crit_cnt; b0 = both_hi;
    issue(2'b11, 11'h001, 11'h002, 4'd14, line_of(32'h5500_0000));
    wait_done("wbf_timeout");
    chk("wbf_done_cyc", 512'(done_cyc - base), 512'(66));
    chk("wbf_done_cnt", 512'(done_cnt - d0), 512'(1));
    chk("wbf_wr_addr", got_wr(w0), exp_addrs(11'h001, 0));
    chk("wbf_rd_addr", got_rd(r0), exp_addrs(11'h002, TbCrit ? 14 : 0));
    chk("wbf_last_wr", 512'(last_wr - base), 512'(32));
    chk("wbf_rd_rise", 512'(rd_rise - base), 512'(33));
    chk("wbf_both_hi", 512'(both_hi - b0), 512'(0));
    chk("wbf_idx", got_idx(i0), exp_idx(TbCrit ? 14 : 0));
    chk("wbf_crit_cnt", 512'(crit_cnt - c0), 512'(TbCrit ? 1 : 0));
    chk("wbf_crit_idx", 512'(crit_idx), 512'(TbCrit ? 14 : 0));
    chk("wbf_line", done_line, line_of(32'hC0DE_0020));
    for (int k = 0; k < 16; k++) obs[k*N +: N] = ram[15'h0010 + 15'(k)];
    chk("wbf_ram", obs, line_of(32'h5500_0000));

    // Reset during the 5th read word aborts the FILL
    d0 = done_cnt;
    issue(2'b01, 11'h000, 11'h003, 4'h0, '0);
    wait_rel(9);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_req", 512'({bus.L2_read_request, bus.L2_write_request}), 512'(0));
    chk("abort_busy", 512'(bus.eng_busy), 512'(0));
    chk("abort_line", bus.fill_line, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 512'(done_cnt - d0), 512'(0));

    // New FILL; a WB start while busy must be ignored
    d0 = done_cnt; i0 = n_idx; r0 = n_rd; w0 = n_wr;
    issue(2'b01, 11'h000, 11'h004, 4'h0, '0);
    wait_rel(5);
    bus.start    = 1'b1;
    bus.op       = 2'b10;
    bus.wb_block = 11'h006;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    wait_done("refill_timeout");
    chk("refill_done_cyc", 512'(done_cyc - base), 512'(34));
    chk("refill_done_cnt", 512'(done_cnt - d0), 512'(1));
    chk("refill_wr_cnt", 512'(n_wr - w0), 512'(0));
    chk("refill_addr", got_rd(r0), exp_addrs(11'h004, 0));
    chk("refill_line", done_line, line_of(32'hC0DE_0040));
    chk("refill_idle", 512'(bus.eng_busy), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
